// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, reset constants and fetch-state type for the MIPS front end
package mips_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and clear controls
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] d_instr,
    input  logic [XLEN-1:0] d_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            instr    <= NOP;
            pc       <= RESET_PC;
            pc_plus4 <= RESET_PC + 32'd4;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= d_instr;
            pc       <= d_pc;
            pc_plus4 <= d_pc + 32'd4;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= NOP;
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM with one-entry skid buffer feeding IF/ID.
// Define IF_DELAY_SLOT_EN to keep the IF/ID entry across a flush (branch delay slot).
module if_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            pc_advance,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4
);
    fetch_state_t    state;
    logic [XLEN-1:0] skid_instr, skid_pc;
    logic            accept, unhold, load, clear, flush_clears;
`ifdef IF_DELAY_SLOT_EN
    assign flush_clears = 1'b0;
`else
    assign flush_clears = 1'b1;
`endif
    assign imem_req   = state == S_REQ;
    assign imem_addr  = pc_in;
    assign accept     = imem_req && imem_ready && !flush && !reset;
    assign pc_advance = accept;
    assign unhold     = state == S_HOLD && !stall && !flush;
    assign load       = !stall && (accept || unhold);
    // with nothing to load and decode free, the slot empties to a bubble
    assign clear      = flush ? flush_clears : !stall && !load;

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .clear    (clear),
        .d_instr  (accept ? imem_rdata : skid_instr),
        .d_pc     (accept ? pc_in : skid_pc),
        .valid    (instr_valid),
        .instr    (instr),
        .pc       (instr_pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            skid_instr <= NOP;
            skid_pc    <= RESET_PC;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            state <= state == S_IDLE ? S_REQ :
                     state == S_REQ  ? (accept && stall ? S_HOLD : S_REQ) :
                     (stall ? S_HOLD : S_REQ);
            if (accept && stall) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc_in;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a queue-based fetch model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, imem_ready;
    logic [31:0] pc_in, imem_rdata;
    logic        imem_req, pc_advance, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc, pc_plus4;
    int          total = 0;
    int          bad = 0;
`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_advance (pc_advance),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .pc_plus4   (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, s, f, rdy, input logic [31:0] pc, d);
        reset = r; stall = s; flush = f; imem_ready = rdy; pc_in = pc; imem_rdata = d;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // leaves the fetcher one cycle out of reset, i.e. requesting
    task automatic do_reset;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        drive(1, 0, 0, 1, 32'h40, 32'h1111_2222);
        total++;
        if (pc_advance !== 1'b0) begin
            bad++; $display("FAIL reset_adv_during_reset got=%b exp=0", pc_advance);
        end
        tick();
        drive(1, 0, 0, 1, 32'h40, 32'h1111_2222);
        total++;
        if ({imem_req, pc_advance, instr_valid, instr, instr_pc, pc_plus4} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            bad++; $display("FAIL reset_values got=%b%b%b %h %h %h exp=000 0 0 4", imem_req, pc_advance, instr_valid, instr, instr_pc, pc_plus4);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (imem_req !== 1'b1) begin
            bad++; $display("FAIL reset_then_req got=%b exp=1", imem_req);
        end
    endtask

    task automatic test_single_cycle;
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            w = $urandom;
            drive(0, 0, 0, 1, 32'(4 * k), w);
            total++;
            if ({imem_req, pc_advance, imem_addr} !== {1'b1, 1'b1, 32'(4 * k)}) begin
                bad++; $display("FAIL single_req k=%0d got=%b%b %h exp=11 %h", k, imem_req, pc_advance, imem_addr, 32'(4 * k));
            end
            tick();
            total++;
            if ({instr_valid, instr, instr_pc, pc_plus4} !== {1'b1, w, 32'(4 * k), 32'(4 * k + 4)}) begin
                bad++; $display("FAIL single_ifid k=%0d got=%b %h %h %h exp=1 %h %h %h", k, instr_valid, instr, instr_pc, pc_plus4, w, 32'(4 * k), 32'(4 * k + 4));
            end
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 32'h100, $urandom);
            total++;
            if ({imem_req, pc_advance, imem_addr} !== {1'b1, 1'b0, 32'h100}) begin
                bad++; $display("FAIL wait_req i=%0d got=%b%b %h exp=10 100", i, imem_req, pc_advance, imem_addr);
            end
            tick();
            total++;
            if ({instr_valid, instr} !== {1'b0, 32'h0}) begin
                bad++; $display("FAIL wait_bubble i=%0d got=%b %h exp=0 0", i, instr_valid, instr);
            end
        end
        w = $urandom;
        drive(0, 0, 0, 1, 32'h100, w);
        total++;
        if (pc_advance !== 1'b1) begin
            bad++; $display("FAIL wait_adv got=%b exp=1", pc_advance);
        end
        tick();
        total++;
        if ({instr_valid, instr, instr_pc, pc_plus4} !== {1'b1, w, 32'h100, 32'h104}) begin
            bad++; $display("FAIL wait_ifid got=%b %h %h %h exp=1 %h 100 104", instr_valid, instr, instr_pc, pc_plus4, w);
        end
    endtask

    task automatic test_stall_skid;
        logic [31:0] w0;
        do_reset();
        w0 = $urandom;
        drive(0, 0, 0, 1, 32'h1FC, w0);
        tick();
        drive(0, 1, 0, 1, 32'h200, 32'hDEAD_BEEF);
        total++;
        if (pc_advance !== 1'b1) begin
            bad++; $display("FAIL skid_adv got=%b exp=1", pc_advance);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 1, 32'h204, $urandom);
            total++;
            if ({imem_req, pc_advance, instr_valid, instr, instr_pc} !== {1'b0, 1'b0, 1'b1, w0, 32'h1FC}) begin
                bad++; $display("FAIL skid_hold i=%0d got=%b%b%b %h %h exp=001 %h 1fc", i, imem_req, pc_advance, instr_valid, instr, instr_pc, w0);
            end
            tick();
        end
        drive(0, 0, 0, 0, 32'h204, 0);
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL skid_release_req got=%b exp=0", imem_req);
        end
        tick();
        drive(0, 0, 0, 0, 32'h204, 0);
        total++;
        if ({instr_valid, instr, instr_pc, pc_plus4} !== {1'b1, 32'hDEAD_BEEF, 32'h200, 32'h204}) begin
            bad++; $display("FAIL skid_drain got=%b %h %h %h exp=1 deadbeef 200 204", instr_valid, instr, instr_pc, pc_plus4);
        end
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h204}) begin
            bad++; $display("FAIL skid_resume got=%b %h exp=1 204", imem_req, imem_addr);
        end
    endtask

    task automatic test_flush_stall;
        logic [31:0] w0, w1;
        do_reset();
        w0 = $urandom;
        w1 = $urandom;
        drive(0, 0, 0, 1, 32'h300, w0);
        tick();
        drive(0, 1, 1, 1, 32'h304, 32'h1234_5678);
        total++;
        if (pc_advance !== 1'b0) begin
            bad++; $display("FAIL flush_adv got=%b exp=0", pc_advance);
        end
        tick();
        drive(0, 0, 0, 0, 32'h400, 0);
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL flush_idle got=%b exp=0", imem_req);
        end
        total++;
        if ({instr_valid, instr} !== (DS ? {1'b1, w0} : {1'b0, 32'h0})) begin
            bad++; $display("FAIL flush_ifid got=%b %h exp=%b %h", instr_valid, instr, DS, DS ? w0 : 32'h0);
        end
        tick();
        drive(0, 0, 0, 1, 32'h400, w1);
        total++;
        if ({imem_req, pc_advance, imem_addr} !== {1'b1, 1'b1, 32'h400}) begin
            bad++; $display("FAIL flush_refetch got=%b%b %h exp=11 400", imem_req, pc_advance, imem_addr);
        end
        tick();
        total++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, w1, 32'h400}) begin
            bad++; $display("FAIL flush_target got=%b %h %h exp=1 %h 400", instr_valid, instr, instr_pc, w1);
        end
    endtask

    task automatic test_flush_valid;
        logic [31:0] w0;
        do_reset();
        w0 = $urandom;
        drive(0, 0, 0, 1, 32'h500, w0);
        tick();
        drive(0, 0, 1, 0, 32'h504, 0);
        tick();
        total++;
        if ({instr_valid, instr} !== (DS ? {1'b1, w0} : {1'b0, 32'h0})) begin
            bad++; $display("FAIL flush_valid got=%b %h exp=%b %h", instr_valid, instr, DS, DS ? w0 : 32'h0);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] w;
        do_reset();
        w = $urandom;
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, w);
        tick();
        total++;
        if ({instr_valid, instr, instr_pc, pc_plus4} !== {1'b1, w, 32'hFFFF_FFFC, 32'h0}) begin
            bad++; $display("FAIL wrap got=%b %h %h %h exp=1 %h fffffffc 0", instr_valid, instr, instr_pc, pc_plus4, w);
        end
    endtask

    task automatic test_reset_in_hold;
        do_reset();
        drive(0, 0, 0, 1, 32'h600, $urandom);
        tick();
        drive(0, 1, 0, 1, 32'h604, $urandom);
        tick();
        drive(0, 1, 0, 0, 32'h608, 0);
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL hold_entered got=%b exp=0", imem_req);
        end
        drive(1, 1, 1, 1, 32'h608, 0);
        tick();
        drive(0, 0, 0, 1, 32'h608, $urandom);
        total++;
        if ({imem_req, pc_advance, instr_valid, instr, instr_pc, pc_plus4} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            bad++; $display("FAIL hold_reset got=%b%b%b %h %h %h exp=000 0 0 4", imem_req, pc_advance, instr_valid, instr, instr_pc, pc_plus4);
        end
        tick();
        drive(0, 0, 0, 0, 32'h608, 0);
        total++;
        if (imem_req !== 1'b1) begin
            bad++; $display("FAIL hold_reset_skid_empty got=%b exp=1", imem_req);
        end
    endtask

    // model: a restart flag after flush, a queue for the parked word, and the IF/ID contents
    task automatic test_random;
        bit          restarting, ev, s, f, r, exp_req, exp_adv;
        logic [31:0] ei, ep, pc, d;
        logic [31:0] wq[$], pq[$];
        do_reset();
        restarting = 0;
        ev = 0;
        ei = 0;
        ep = 0;
        pc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            s = $urandom_range(0, 9) < 3;
            f = $urandom_range(0, 15) == 0;
            r = $urandom_range(0, 9) < 6;
            d = $urandom;
            drive(0, s, f, r, pc, d);
            exp_req = !restarting && wq.size() == 0;
            exp_adv = exp_req && r && !f;
            total++;
            if ({imem_req, pc_advance} !== {exp_req, exp_adv}) begin
                bad++; $display("FAIL rand_ctrl n=%0d got=%b%b exp=%b%b", n, imem_req, pc_advance, exp_req, exp_adv);
            end
            if (exp_req) begin
                total++;
                if (imem_addr !== pc) begin
                    bad++; $display("FAIL rand_addr n=%0d got=%h exp=%h", n, imem_addr, pc);
                end
            end
            if (f) begin
                wq.delete();
                pq.delete();
                restarting = 1;
                if (!DS) begin ev = 0; ei = 0; end
            end else begin
                if (exp_adv && !s) begin
                    ev = 1; ei = d; ep = pc;
                end else if (exp_adv) begin
                    wq.push_back(d); pq.push_back(pc);
                end else if (wq.size() != 0 && !s) begin
                    ev = 1; ei = wq.pop_front(); ep = pq.pop_front();
                end else if (!s) begin
                    ev = 0; ei = 0;
                end
                restarting = 0;
            end
            if (f) begin
                pc = $urandom;
                pc = pc & 32'hFFFF_FFFC;
            end else if (exp_adv) begin
                pc = pc + 32'd4;
            end
            tick();
            total++;
            if ({instr_valid, instr} !== {ev, ei}) begin
                bad++; $display("FAIL rand_ifid n=%0d got=%b %h exp=%b %h", n, instr_valid, instr, ev, ei);
            end
            if (ev) begin
                total++;
                if ({instr_pc, pc_plus4} !== {ep, ep + 32'd4}) begin
                    bad++; $display("FAIL rand_pc n=%0d got=%h %h exp=%h %h", n, instr_pc, pc_plus4, ep, ep + 32'd4);
                end
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        test_reset();
        test_single_cycle();
        test_wait_states();
        test_stall_skid();
        test_flush_stall();
        test_flush_valid();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset; sampled on rising clk.
REQ-003 pc_in  in  32  current fetch address from the PC register.
REQ-004 stall  in  1  decode stage cannot accept a new instruction this cycle.
REQ-005 flush  in  1  control-flow redirect; pc_in carries the new target from the next cycle.
REQ-006 imem_req  out  1  instruction memory read request.
REQ-007 imem_addr  out  32  word address of the request, equal to the latched fetch PC.
REQ-008 imem_ready  in  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-009 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-010 pc_advance  out  1  one-cycle pulse: the fetched word was accepted, so the PC may load pc+4 or a jump target.
REQ-011 instr_valid  out  1  IF/ID register holds a live instruction.
REQ-012 instr  out  32  IF/ID instruction; NOP (32'h0000_0000) when not valid.
REQ-013 instr_pc  out  32  address of instr.
REQ-014 pc_plus4  out  32  instr_pc + 4, modulo 2^32.

Function
REQ-015 FSM states: S_IDLE, S_REQ and S_HOLD, encoded in a 2-bit register.
REQ-016 S_IDLE: imem_req=0; the FSM moves to S_REQ on the next cycle.
REQ-017 S_REQ: imem_req=1 and imem_addr=pc_in; both stay stable until imem_ready=1.
REQ-018 S_REQ, imem_ready=1, stall=0:
  - imem_rdata, pc_in and pc_in+4 load into IF/ID;
  - instr_valid is 1 in the next cycle;
  - pc_advance=1 in the same cycle;
  - the FSM stays in S_REQ.
REQ-019 S_REQ, imem_ready=1, stall=1:
  - the word and its PC load into a one-entry skid buffer;
  - pc_advance=1 in the same cycle;
  - the FSM goes to S_HOLD.
REQ-020 S_HOLD:
  - imem_req=0;
  - IF/ID is held;
  - when stall=0, the skid buffer loads into IF/ID and the FSM goes to S_REQ.
REQ-021 With stall=1, IF/ID holds its value in every state.
REQ-022 With stall=0 and no word accepted, instr_valid is 0 in the next cycle and instr is NOP.
REQ-023 Minimum latency is 1 cycle from imem_ready to instr_valid; throughput is one instruction per cycle with a single-cycle memory.
REQ-024 Flush in any state:
  - discards the skid buffer;
  - discards any word returned in the same cycle, and pc_advance=0;
  - sets the FSM to S_IDLE;
  - handles IF/ID as defined in REQ-030.
REQ-025 Flush and stall in the same cycle: flush wins.
REQ-026 Flush during a multi-cycle memory wait abandons the request; the request is reissued to the new pc_in after S_IDLE.
REQ-027 pc_plus4 wraps: a fetch from 32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.

Reset
REQ-028 Reset takes priority over flush and stall.
REQ-029 In the cycle after reset is sampled, outputs are: FSM=S_IDLE, imem_req=0, pc_advance=0, instr_valid=0, instr=NOP, instr_pc=0, pc_plus4=4, skid buffer empty. Reset mid-request abandons the request.

Configuration
REQ-030 Macro IF_DELAY_SLOT_EN, branch delay slot:
  - defined: flush leaves a valid IF/ID entry intact (the delay-slot instruction).
  - undefined: flush clears instr_valid to 0 and instr to NOP in the next cycle.

Structure
REQ-031 Shared package mips_pkg holds:
  - the NOP constant;
  - the RESET_PC constant (32'h0);
  - the word width of 32;
  - the fetch-state enum typedef.
REQ-032 The IF/ID pipeline register is sub-module if_id_reg, with load, hold and clear controls.

Verification
REQ-033 Reset, then a single-cycle memory (ready=1 every request), pc_in stepping 0,4,8 -> instr_pc=0,4,8 on consecutive cycles; pc_advance high each cycle.
REQ-034 Memory ready after 3 cycles at pc_in=32'h100 -> imem_addr stays 32'h100 for 3 cycles; instr_valid rises 1 cycle after ready; pc_plus4=32'h104.
REQ-035 Stall asserted when ready returns 32'hDEAD_BEEF -> FSM in S_HOLD, imem_req=0; 2 cycles later stall drops -> instr=32'hDEAD_BEEF in the next cycle.
REQ-036 Flush together with stall and ready -> returned word dropped, pc_advance=0, imem_req=0 for one cycle, then a request to the new target.
REQ-037 Flush with instr_valid=1 -> without the macro, instr_valid=0 next cycle; with IF_DELAY_SLOT_EN, instr is unchanged.
REQ-038 Fetch at 32'hFFFF_FFFC -> pc_plus4=0; reset asserted in S_HOLD -> all outputs at reset values next cycle.
